// File: rtl/mem_stage_hs.sv
// MEM pipeline stage: holds one load/store to a variable-latency memory (req/ack) and stalls upstream until ack.
// Optional BUSY-timeout abort when MEM_TIMEOUT_EN is defined. DATA_W must be a multiple of 8 and at least 16.
//
// state  | meaning
// IDLE   | accepting a new instruction from EX/MEM
// BUSY   | request outstanding, upstream stalled until mem_ack (or timeout)
module mem_stage_hs #(
    parameter int DATA_W      = 32,
    parameter int REG_W       = 5,
    parameter int WB_CTRL_W   = 3,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid_in,
    input  logic [DATA_W-1:0]      pc_in,
    input  logic [DATA_W-1:0]      addr_in,
    input  logic [DATA_W-1:0]      wdata_in,
    input  logic [DATA_W-1:0]      wb_data,
    input  logic                   forward_e,
    input  logic [WB_CTRL_W+4:0]   ctrl_in,
    input  logic [REG_W-1:0]       regdst_in,
    output logic                   stall_out,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [DATA_W-1:0]      mem_addr,
    output logic [DATA_W-1:0]      mem_wdata,
    output logic [DATA_W/8-1:0]    mem_be,
    input  logic                   mem_ack,
    input  logic [DATA_W-1:0]      mem_rdata,
    output logic                   valid_out,
    output logic [DATA_W-1:0]      pc_out,
    output logic [DATA_W-1:0]      addr_out,
    output logic [DATA_W-1:0]      data_out,
    output logic [WB_CTRL_W-1:0]   ctrl_out,
    output logic [REG_W-1:0]       regdst_out,
    output logic                   misalign_out,
    output logic                   err_out
);

    localparam int LANES = DATA_W / 8;
    localparam int OFF_W = $clog2(LANES);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    localparam logic [LANES-1:0] BE_BYTE = {{(LANES-1){1'b0}}, 1'b1};
    localparam logic [LANES-1:0] BE_HALF = BE_BYTE | (BE_BYTE << 1);

    logic [0:0] state;

    logic                 in_rd;
    logic                 in_wr;
    logic [1:0]           in_size;
    logic                 in_lds;
    logic [OFF_W-1:0]     in_off;
    logic                 in_mem;
    logic                 in_misal;
    logic [DATA_W-1:0]    st_src;
    logic [DATA_W-1:0]    st_lanes;
    logic [LANES-1:0]     st_be;

    logic [DATA_W-1:0]    q_pc;
    logic [DATA_W-1:0]    q_addr;
    logic [WB_CTRL_W-1:0] q_ctrl;
    logic [REG_W-1:0]     q_regdst;
    logic [1:0]           q_size;
    logic                 q_lds;
    logic [OFF_W-1:0]     q_off;

    logic [DATA_W-1:0]    ld_shift;
    logic [DATA_W-1:0]    ld_data;

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    logic [CNT_W-1:0] busy_cnt;
    logic             err_q;
`endif

    assign in_rd   = ctrl_in[WB_CTRL_W];
    assign in_wr   = ctrl_in[WB_CTRL_W+1];
    assign in_size = ctrl_in[WB_CTRL_W+3:WB_CTRL_W+2];
    assign in_lds  = ctrl_in[WB_CTRL_W+4];
    assign in_off  = addr_in[OFF_W-1:0];
    assign in_mem  = in_rd | in_wr;

    // Size 2'b11 behaves as word, so anything not byte/half needs full alignment.
    always_comb begin
        in_misal = 1'b0;
        if (in_size == SZ_HALF)
            in_misal = addr_in[0];
        else if (in_size != SZ_BYTE)
            in_misal = |in_off;
    end

    assign st_src = forward_e ? wb_data : wdata_in;

    always_comb begin
        st_lanes = st_src;
        st_be    = '1;
        if (in_size == SZ_BYTE) begin
            st_lanes = {LANES{st_src[7:0]}};
            st_be    = BE_BYTE << in_off;
        end else if (in_size == SZ_HALF) begin
            st_lanes = {(LANES/2){st_src[15:0]}};
            st_be    = BE_HALF << in_off;
        end
    end

    assign ld_shift = mem_rdata >> {q_off, 3'b000};

    always_comb begin
        ld_data = ld_shift;
        if (q_size == SZ_BYTE)
            ld_data = {{(DATA_W-8){q_lds & ld_shift[7]}}, ld_shift[7:0]};
        else if (q_size == SZ_HALF)
            ld_data = {{(DATA_W-16){q_lds & ld_shift[15]}}, ld_shift[15:0]};
    end

    assign stall_out = (state == S_BUSY);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_be       <= '0;
            valid_out    <= 1'b0;
            pc_out       <= '0;
            addr_out     <= '0;
            data_out     <= '0;
            ctrl_out     <= '0;
            regdst_out   <= '0;
            misalign_out <= 1'b0;
            q_pc         <= '0;
            q_addr       <= '0;
            q_ctrl       <= '0;
            q_regdst     <= '0;
            q_size       <= '0;
            q_lds        <= 1'b0;
            q_off        <= '0;
`ifdef MEM_TIMEOUT_EN
            busy_cnt     <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            valid_out <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (valid_in) begin
                        if (in_mem && !in_misal) begin
                            state     <= S_BUSY;
                            mem_req   <= 1'b1;
                            mem_we    <= in_wr;
                            mem_addr  <= {addr_in[DATA_W-1:OFF_W], {OFF_W{1'b0}}};
                            mem_wdata <= st_lanes;
                            mem_be    <= st_be;
                            q_pc      <= pc_in;
                            q_addr    <= addr_in;
                            q_ctrl    <= ctrl_in[WB_CTRL_W-1:0];
                            q_regdst  <= regdst_in;
                            q_size    <= in_size;
                            q_lds     <= in_lds;
                            q_off     <= in_off;
`ifdef MEM_TIMEOUT_EN
                            busy_cnt  <= '0;
`endif
                        end else begin
                            // Non-memory op or rejected misaligned access retires straight away.
                            valid_out    <= 1'b1;
                            pc_out       <= pc_in;
                            addr_out     <= addr_in;
                            data_out     <= '0;
                            ctrl_out     <= ctrl_in[WB_CTRL_W-1:0];
                            regdst_out   <= regdst_in;
                            misalign_out <= in_mem;
`ifdef MEM_TIMEOUT_EN
                            err_q        <= 1'b0;
`endif
                        end
                    end
                end
                S_BUSY: begin
                    if (mem_ack) begin
                        state        <= S_IDLE;
                        mem_req      <= 1'b0;
                        valid_out    <= 1'b1;
                        pc_out       <= q_pc;
                        addr_out     <= q_addr;
                        data_out     <= mem_we ? '0 : ld_data;
                        ctrl_out     <= q_ctrl;
                        regdst_out   <= q_regdst;
                        misalign_out <= 1'b0;
`ifdef MEM_TIMEOUT_EN
                        err_q        <= 1'b0;
                    end else if (busy_cnt == CNT_LAST) begin
                        state        <= S_IDLE;
                        mem_req      <= 1'b0;
                        valid_out    <= 1'b1;
                        pc_out       <= q_pc;
                        addr_out     <= q_addr;
                        data_out     <= '0;
                        ctrl_out     <= q_ctrl;
                        regdst_out   <= q_regdst;
                        misalign_out <= 1'b0;
                        err_q        <= 1'b1;
                    end else begin
                        busy_cnt     <= busy_cnt + CNT_W'(1);
`endif
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef MEM_TIMEOUT_EN
    assign err_out = err_q;
`else
    assign err_out = 1'b0;
`endif

endmodule
